// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
//  Instruction-memory request/acknowledge bus between the IF-stage fetch
//  controller and the instruction memory.
//  Signals:
//   imem_req   fetch request, driven by the fetch controller
//   imem_addr  fetch address, held stable while imem_req=1 and no ack
//   imem_ack   fetch complete, imem_rdata valid in the same cycle
//   imem_rdata instruction word returned by the memory
//  Modports:
//   master  fetch controller side
//   slave   instruction memory side
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//  IF-stage sequencer. Issues one instruction fetch at a time over the imem
//  req/ack bus, holds the external PC register until the fetch completes,
//  redirects the PC on branch or exception and hands {if_valid, if_inst, if_pc}
//  to the decode stage.
//  Optional feature macro: FETCH_TIMEOUT_EN
//   defined   : an unanswered request that waits TIMEOUT_CYC cycles sends the
//               block to an error state (fetch_err=1) until exc_req or reset.
//   undefined : no timeout, fetch_err tied low, the block waits forever.
//  Ports:
//   clka, rsta              clock (rising edge), asynchronous active-low reset
//   pc_in                   current PC value
//   pc_stall, pc_branch     PC hold / PC load controls
//   pc_branchaddr           PC load value on redirect
//   br_taken, br_target     resolved taken branch from EX (pulse + target)
//   exc_req                 exception redirect pulse
//   hazard_stall            ID cannot accept if_inst this cycle
//   imem                    instruction-memory bus (master side)
//   if_valid/if_inst/if_pc  registered instruction handed to ID
//   fetch_err               sticky fetch timeout flag
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h8000_0180,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clka,
  input  logic        rsta,
  input  logic [31:0] pc_in,
  output logic        pc_stall,
  output logic        pc_branch,
  output logic [31:0] pc_branchaddr,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        hazard_stall,
  fetch_ctrl_if.master imem,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] addr_q_r;
  logic        if_valid_r;
  logic [31:0] if_inst_r;
  logic [31:0] if_pc_r;
  logic        redirect_s;
  logic        accept_s;
  logic        tmo_last_s;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_r;
  logic             fetch_err_r;

  assign tmo_last_s = (tmo_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
  assign fetch_err  = fetch_err_r;
`else
  logic [31:0] unused_timeout_s;

  assign unused_timeout_s = 32'(TIMEOUT_CYC);
  assign tmo_last_s       = 1'b0;
  assign fetch_err        = 1'b0;
`endif

  assign if_valid = if_valid_r;
  assign if_inst  = if_inst_r;
  assign if_pc    = if_pc_r;

  // Next-state and handshake/PC control decode.
  always_comb begin
    state_nxt_s    = state_r;
    imem.imem_req  = 1'b0;
    imem.imem_addr = addr_q_r;
    pc_stall       = 1'b1;
    pc_branch      = 1'b0;
    pc_branchaddr  = exc_req ? EXC_VECTOR : br_target;
    redirect_s     = 1'b0;
    accept_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // PC register settles to its reset vector during this cycle.
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        // Hold off a new fetch while ID still owns an unconsumed word.
        imem.imem_req  = ~(if_valid_r & hazard_stall);
        imem.imem_addr = pc_in;
        redirect_s     = br_taken | exc_req;
        accept_s       = imem.imem_ack & imem.imem_req & ~redirect_s;
        if (redirect_s) begin
          pc_branch = 1'b1;
          pc_stall  = 1'b0;
          // An outstanding request must still be answered before refetching.
          if (imem.imem_req & ~imem.imem_ack) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else if (accept_s) begin
          pc_stall = 1'b0;
        end else if (imem.imem_req & ~imem.imem_ack & tmo_last_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // Finish the abandoned request at its original address; data is dropped.
        imem.imem_req  = 1'b1;
        imem.imem_addr = addr_q_r;
        redirect_s     = br_taken | exc_req;
        if (redirect_s) begin
          pc_branch = 1'b1;
          pc_stall  = 1'b0;
        end else begin
          pc_stall = 1'b1;
        end
        if (imem.imem_ack) begin
          state_nxt_s = ST_FETCH;
        end else if (~redirect_s & tmo_last_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_ERR: begin
        // Only an exception can leave the error state; branches are ignored.
        redirect_s = exc_req;
        if (exc_req) begin
          pc_branch     = 1'b1;
          pc_stall      = 1'b0;
          pc_branchaddr = EXC_VECTOR;
          state_nxt_s   = ST_FETCH;
        end else begin
          state_nxt_s = ST_ERR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and fetch address capture.
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state_r  <= ST_IDLE;
      addr_q_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_FETCH) begin
        addr_q_r <= pc_in;
      end
    end
  end

  // Registered instruction presented to ID, with flush on redirect or error.
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      if_valid_r <= 1'b0;
      if_inst_r  <= 32'h0000_0000;
      if_pc_r    <= 32'h0000_0000;
    end else if (redirect_s || (state_nxt_s == ST_ERR)) begin
      if_valid_r <= 1'b0;
    end else if (accept_s) begin
      if_valid_r <= 1'b1;
      if_inst_r  <= imem.imem_rdata;
      if_pc_r    <= pc_in;
    end else if (if_valid_r && !hazard_stall) begin
      if_valid_r <= 1'b0;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Wait counter for an unanswered request and the sticky error flag.
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      tmo_cnt_r   <= '0;
      fetch_err_r <= 1'b0;
    end else begin
      fetch_err_r <= (state_nxt_s == ST_ERR);
      if (redirect_s || imem.imem_ack || (state_r == ST_IDLE) || (state_r == ST_ERR)) begin
        tmo_cnt_r <= '0;
      end else if (imem.imem_req) begin
        tmo_cnt_r <= tmo_last_s ? '0 : tmo_cnt_r + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//  Bench for fetch_ctrl: a cycle table of directed vectors, hand-written reset
//  and timeout sequences, then randomized traffic checked against an
//  instruction-stream model (each word handed to ID must be the next
//  sequential address of the current stream, carrying that address's data).
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
  localparam logic [31:0] RST_VEC = 32'h8000_0000;
  localparam logic [31:0] EXC_VEC = 32'h8000_0180;

  logic        clka = 1'b0;
  logic        rsta = 1'b0;
  logic [31:0] pc_in;
  logic        pc_stall, pc_branch;
  logic [31:0] pc_branchaddr;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0000_0000;
  logic        exc_req = 1'b0;
  logic        hazard_stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_inst, if_pc;
  logic        fetch_err;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_ctrl_if imem_bus();

  fetch_ctrl #(.EXC_VECTOR(EXC_VEC), .TIMEOUT_CYC(16)) dut (
    .clka(clka), .rsta(rsta), .pc_in(pc_in), .pc_stall(pc_stall),
    .pc_branch(pc_branch), .pc_branchaddr(pc_branchaddr), .br_taken(br_taken),
    .br_target(br_target), .exc_req(exc_req), .hazard_stall(hazard_stall),
    .imem(imem_bus), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .fetch_err(fetch_err)
  );

  always #5 clka = ~clka;

  // External PC register: load on branch, else advance unless stalled.
  always @(posedge clka or negedge rsta) begin
    if (!rsta) pc_in <= RST_VEC;
    else if (pc_branch) pc_in <= pc_branchaddr;
    else if (!pc_stall) pc_in <= pc_in + 32'd4;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        hz, br, exc, ack;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_stall, e_br;
    logic [31:0] e_baddr;
    logic        e_valid;
    logic [31:0] e_ifpc;
  } vec_t;

  function automatic vec_t mk(input logic hz, input logic br, input logic exc, input logic ack,
                              input logic [31:0] tgt, input logic e_req, input logic [31:0] e_addr,
                              input logic e_stall, input logic e_br, input logic [31:0] e_baddr,
                              input logic e_valid, input logic [31:0] e_ifpc);
    vec_t v;
    v.hz = hz; v.br = br; v.exc = exc; v.ack = ack; v.tgt = tgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_stall = e_stall; v.e_br = e_br;
    v.e_baddr = e_baddr; v.e_valid = e_valid; v.e_ifpc = e_ifpc;
    return v;
  endfunction

  vec_t vt[22];

  // Drive inputs at the current falling edge, answer imem, then let outputs settle.
  task automatic apply(input logic hz, input logic br, input logic exc,
                       input logic [31:0] tgt, input logic ack);
    hazard_stall = hz; br_taken = br; exc_req = exc; br_target = tgt;
    #1;
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = memfn(imem_bus.imem_addr);
    #1;
  endtask

  logic        busy, ack_r, prev_pend, redir;
  int          rem, gap;
  logic [31:0] prev_addr, exp_pc, tgt_r;

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0000_0000;

    //      hz    br    exc   ack   tgt            req   addr           stall br    baddr          valid ifpc
    vt[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
    vt[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0);
    vt[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0000);
    vt[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0004);
    vt[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_000C, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0008);
    vt[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_000C, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
    vt[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_000C, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
    vt[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h8000_000C, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0);
    vt[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_000C);
    vt[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_000C);
    vt[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_000C);
    vt[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0014, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0010);
    vt[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_1000, 1'b1, 32'h8000_0014, 1'b0, 1'b1, 32'h8000_1000, 1'b0, 32'h0);
    vt[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0014, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
    vt[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h8000_0014, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
    vt[15] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h8000_1000, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0);
    vt[16] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h8000_1000, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0180, 1'b1, 32'h8000_1000);
    vt[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0180, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
    vt[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h8000_0180, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0);
    vt[19] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_2000, 1'b1, 32'h8000_0184, 1'b0, 1'b1, 32'h8000_2000, 1'b1, 32'h8000_0180);
    vt[20] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h8000_2000, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0);
    vt[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_2004, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_2000);

    // Reset state while rsta is held low.
    repeat (3) @(posedge clka);
    @(negedge clka);
    #2;
    chk("rst if_valid", 32'(if_valid), 32'd0);
    chk("rst if_inst", if_inst, 32'h0);
    chk("rst if_pc", if_pc, 32'h0);
    chk("rst fetch_err", 32'(fetch_err), 32'd0);
    chk("rst imem_req", 32'(imem_bus.imem_req), 32'd0);
    chk("rst pc_stall", 32'(pc_stall), 32'd1);
    @(negedge clka);
    rsta = 1'b1;

    // Directed cycle table.
    for (int i = 0; i < 22; i++) begin
      apply(vt[i].hz, vt[i].br, vt[i].exc, vt[i].tgt, vt[i].ack);
      chk($sformatf("vec%0d imem_req", i), 32'(imem_bus.imem_req), 32'(vt[i].e_req));
      if (vt[i].e_req) chk($sformatf("vec%0d imem_addr", i), imem_bus.imem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d pc_stall", i), 32'(pc_stall), 32'(vt[i].e_stall));
      chk($sformatf("vec%0d pc_branch", i), 32'(pc_branch), 32'(vt[i].e_br));
      if (vt[i].e_br) chk($sformatf("vec%0d pc_branchaddr", i), pc_branchaddr, vt[i].e_baddr);
      chk($sformatf("vec%0d if_valid", i), 32'(if_valid), 32'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d if_pc", i), if_pc, vt[i].e_ifpc);
        chk($sformatf("vec%0d if_inst", i), if_inst, memfn(vt[i].e_ifpc));
      end
      chk($sformatf("vec%0d fetch_err", i), 32'(fetch_err), 32'd0);
      @(negedge clka);
    end

    // Reset asserted with a request outstanding: outputs clear at once.
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    rsta = 1'b0;
    #1;
    chk("midrst if_valid", 32'(if_valid), 32'd0);
    chk("midrst if_pc", if_pc, 32'h0);
    chk("midrst if_inst", if_inst, 32'h0);
    chk("midrst imem_req", 32'(imem_bus.imem_req), 32'd0);
    chk("midrst pc_stall", 32'(pc_stall), 32'd1);
    @(negedge clka);
    rsta = 1'b1;

    // No ack at all: request must hold for 16 cycles.
    @(negedge clka);
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk($sformatf("wait%0d imem_req", i), 32'(imem_bus.imem_req), 32'd1);
      chk($sformatf("wait%0d imem_addr", i), imem_bus.imem_addr, RST_VEC);
      chk($sformatf("wait%0d fetch_err", i), 32'(fetch_err), 32'd0);
      @(negedge clka);
    end
    apply(1'b0, 1'b1, 1'b0, 32'h8000_4000, 1'b0);
`ifdef FETCH_TIMEOUT_EN
    chk("tmo fetch_err", 32'(fetch_err), 32'd1);
    chk("tmo imem_req", 32'(imem_bus.imem_req), 32'd0);
    chk("tmo pc_stall", 32'(pc_stall), 32'd1);
    chk("tmo if_valid", 32'(if_valid), 32'd0);
    chk("tmo br ignored", 32'(pc_branch), 32'd0);
    @(negedge clka);
    apply(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    chk("tmo exc pc_branch", 32'(pc_branch), 32'd1);
    chk("tmo exc pc_branchaddr", pc_branchaddr, EXC_VEC);
    @(negedge clka);
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("tmo exit fetch_err", 32'(fetch_err), 32'd0);
    chk("tmo exit imem_req", 32'(imem_bus.imem_req), 32'd1);
    chk("tmo exit imem_addr", imem_bus.imem_addr, EXC_VEC);
`else
    chk("notmo fetch_err", 32'(fetch_err), 32'd0);
    chk("notmo imem_req", 32'(imem_bus.imem_req), 32'd1);
    chk("notmo pc_branch", 32'(pc_branch), 32'd1);
`endif
    @(negedge clka);
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic against the instruction-stream model.
    rsta = 1'b0;
    @(negedge clka);
    rsta = 1'b1;
    busy = 1'b0; rem = 0; prev_pend = 1'b0; prev_addr = 32'h0;
    exp_pc = RST_VEC; gap = 0;
    for (int c = 0; c < 3000; c++) begin
      hazard_stall = ($urandom_range(0, 3) == 0);
      br_taken     = (c > 0) && ($urandom_range(0, 15) == 0);
      exc_req      = (c > 0) && ($urandom_range(0, 31) == 0);
      tgt_r        = {16'h8000, 14'($urandom), 2'b00};
      br_target    = tgt_r;
      #1;
      if (imem_bus.imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          rem  = $urandom_range(0, 4);
        end
        ack_r = (rem == 0);
        if (ack_r) busy = 1'b0;
        else rem--;
      end else begin
        busy  = 1'b0;
        ack_r = 1'b0;
      end
      imem_bus.imem_ack   = ack_r;
      imem_bus.imem_rdata = memfn(imem_bus.imem_addr);
      #1;
      redir = br_taken | exc_req;
      if (prev_pend && imem_bus.imem_req) chk("rnd addr_hold", imem_bus.imem_addr, prev_addr);
      chk("rnd pc_branch", 32'(pc_branch), 32'(redir));
      if (redir) begin
        chk("rnd pc_branchaddr", pc_branchaddr, exc_req ? EXC_VEC : tgt_r);
        chk("rnd redirect pc_stall", 32'(pc_stall), 32'd0);
      end
      chk("rnd fetch_err", 32'(fetch_err), 32'd0);
      if (if_valid && !hazard_stall && !redir) begin
        chk("rnd if_pc", if_pc, exp_pc);
        chk("rnd if_inst", if_inst, memfn(exp_pc));
        exp_pc = exp_pc + 32'd4;
        gap = 0;
      end else begin
        gap++;
      end
      if (redir) exp_pc = exc_req ? EXC_VEC : tgt_r;
      if (gap > 100) begin
        n_chk++;
        n_fail++;
        $display("FAIL rnd progress: no instruction delivered for %0d cycles, required at most 100", gap);
        break;
      end
      prev_pend = imem_bus.imem_req & ~ack_r;
      prev_addr = imem_bus.imem_addr;
      @(negedge clka);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
